// File: rtl/spi_gphy_ctrl_mlane_if.sv
// SPI slave bus bundle for the GPHY control block (clock, data in, chip select).
`timescale 1ns/1ps
interface spi_gphy_ctrl_mlane_if;
  logic sclk;
  logic mosi;
  logic cs;

  modport master (output sclk, output mosi, output cs);
  modport slave  (input  sclk, input  mosi, input  cs);
endinterface

// File: rtl/spi_gphy_ctrl_mlane.sv
// SPI-controlled register block for a multi-lane GPHY: control, TX words, status snapshot, error counters.
`timescale 1ns/1ps
module spi_gphy_ctrl_mlane #(
  parameter int unsigned LANES     = 2,
  parameter logic [6:0]  param_adr = 7'd1,
  parameter logic [15:0] ID_VER    = 16'h0002
) (
  input  logic                   clk,
  input  logic                   rst,
  spi_gphy_ctrl_mlane_if.slave   spi,
  output tri                     miso,
  output logic                   reset_PHY,
  input  logic                   pll_locked,
  input  logic [LANES-1:0]       tx_ready,
  input  logic [LANES-1:0]       rx_ready,
  input  logic [2*LANES-1:0]     rx_runningdisp,
  input  logic [2*LANES-1:0]     rx_disperr,
  input  logic [2*LANES-1:0]     rx_errdetect,
  input  logic [2*LANES-1:0]     rx_datak,
  input  logic [16*LANES-1:0]    rx_parallel_data,
  output logic [16*LANES-1:0]    tx_parallel_data,
  output logic [2*LANES-1:0]     tx_datak
);

  localparam int unsigned CNT_W = 6;

  typedef enum logic [2:0] {IDLE, ADDR, INDEX, DATA, IGNORE} state_t;

  state_t           state;
  logic [1:0]       sclk_sync, mosi_sync, cs_sync;
  logic             sclk_d, cs_d;
  logic [CNT_W-1:0] bit_cnt;
  logic             rw;
  logic [7:0]       idx;
  logic [31:0]      shift;
  logic             rd_load, wr_pend;
  logic [31:0]      rd_data_c;
  logic [LANES-1:0] clr_c;

  logic                snap_pll;
  logic [LANES-1:0]    snap_txr, snap_rxr;
  logic [2*LANES-1:0]  snap_rd, snap_de, snap_ed, snap_dk;
  logic [16*LANES-1:0] snap_data;

  logic [15:0] disp_cnt [LANES];
  logic [15:0] det_cnt  [LANES];

  wire       mosi_s    = mosi_sync[1];
  wire       cs_s      = cs_sync[1];
  wire       rise_c    = sclk_sync[1] & ~sclk_d;
  wire       cs_fall_c = cs_d & ~cs_s;
  wire [7:0] byte_c    = {shift[6:0], mosi_s};

  // Only a read data phase owns the line; released otherwise.
  assign miso = (state == DATA && !rw) ? shift[31] : 1'bz;

  // Two-flop synchronisers plus one history flop for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], spi.sclk};
      mosi_sync <= {mosi_sync[0], spi.mosi};
      cs_sync   <= {cs_sync[0], spi.cs};
      sclk_d    <= sclk_sync[1];
      cs_d      <= cs_sync[1];
    end
  end

  // Frame FSM: header decode, read preload, data shifting and write request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      rw      <= 1'b0;
      idx     <= '0;
      shift   <= '0;
      rd_load <= 1'b0;
      wr_pend <= 1'b0;
    end else begin
      rd_load <= 1'b0;
      wr_pend <= 1'b0;
      if (rd_load) shift <= rd_data_c;
      if (cs_s) begin
        state   <= IDLE;
        bit_cnt <= '0;
      end else if (state == IDLE) begin
        if (cs_fall_c) begin
          state   <= ADDR;
          bit_cnt <= '0;
        end
      end else if (rise_c && state != IGNORE) begin
        shift   <= {shift[30:0], mosi_s};
        bit_cnt <= bit_cnt + CNT_W'(1);
        case (state)
          ADDR: if (bit_cnt == CNT_W'(7)) begin
            rw      <= byte_c[7];
            state   <= (byte_c[6:0] == param_adr) ? INDEX : IGNORE;
            bit_cnt <= '0;
          end
          INDEX: if (bit_cnt == CNT_W'(7)) begin
            idx     <= byte_c;
            state   <= DATA;
            bit_cnt <= '0;
            rd_load <= ~rw;
          end
          DATA: if (bit_cnt == CNT_W'(31)) begin
            wr_pend <= rw;
            state   <= IGNORE;
            bit_cnt <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  // Register read mux; lanes beyond LANES and unmapped indices read 0.
  always_comb begin
    rd_data_c = '0;
    if (idx == 8'h00) rd_data_c = {31'b0, reset_PHY};
    if (idx == 8'h01) rd_data_c = {8'hA5, 8'(LANES), ID_VER};
    for (int n = 0; n < int'(LANES); n++) begin
      if (idx == 8'(16 + n))
        rd_data_c = {14'b0, tx_datak[2*n +: 2], tx_parallel_data[16*n +: 16]};
      if (idx == 8'(32 + n))
        rd_data_c = {5'b0, snap_pll, snap_txr[n], snap_rxr[n], snap_rd[2*n +: 2],
                     snap_de[2*n +: 2], snap_ed[2*n +: 2], snap_dk[2*n +: 2],
                     snap_data[16*n +: 16]};
      if (idx == 8'(48 + n))
        rd_data_c = {disp_cnt[n], det_cnt[n]};
    end
  end

  // Counter clear requests: CTRL bit1 clears every lane, an ERRCNT write clears its lane.
  always_comb begin
    clr_c = '0;
    for (int n = 0; n < int'(LANES); n++)
      clr_c[n] = wr_pend && ((idx == 8'h00 && shift[1]) || idx == 8'(48 + n));
  end

  // Writable registers, committed the clock after the last data bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reset_PHY        <= 1'b0;
      tx_parallel_data <= '0;
      tx_datak         <= '0;
    end else if (wr_pend) begin
      if (idx == 8'h00) reset_PHY <= shift[0];
      for (int n = 0; n < int'(LANES); n++) begin
        if (idx == 8'(16 + n)) begin
          tx_parallel_data[16*n +: 16] <= shift[15:0];
          tx_datak[2*n +: 2]           <= shift[17:16];
        end
      end
    end
  end

  // Status snapshot tracks inputs while deselected, frozen for the duration of a frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_pll  <= 1'b0;
      snap_txr  <= '0;
      snap_rxr  <= '0;
      snap_rd   <= '0;
      snap_de   <= '0;
      snap_ed   <= '0;
      snap_dk   <= '0;
      snap_data <= '0;
    end else if (cs_s) begin
      snap_pll  <= pll_locked;
      snap_txr  <= tx_ready;
      snap_rxr  <= rx_ready;
      snap_rd   <= rx_runningdisp;
      snap_de   <= rx_disperr;
      snap_ed   <= rx_errdetect;
      snap_dk   <= rx_datak;
      snap_data <= rx_parallel_data;
    end
  end

  // Saturating per-lane error counters; a clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < int'(LANES); n++) begin
        disp_cnt[n] <= '0;
        det_cnt[n]  <= '0;
      end
    end else begin
      for (int n = 0; n < int'(LANES); n++) begin
        if (clr_c[n]) begin
          disp_cnt[n] <= '0;
          det_cnt[n]  <= '0;
        end else begin
          if (|rx_disperr[2*n +: 2] && disp_cnt[n] != 16'hFFFF)
            disp_cnt[n] <= disp_cnt[n] + 16'd1;
          if (|rx_errdetect[2*n +: 2] && det_cnt[n] != 16'hFFFF)
            det_cnt[n] <= det_cnt[n] + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_gphy_ctrl_mlane.sv
// Randomised bench for spi_gphy_ctrl_mlane with a register-map reference model.
`timescale 1ns/1ps
module tb_spi_gphy_ctrl_mlane;
  localparam int unsigned LANES = 2;
  localparam logic [6:0]  ADR   = 7'd1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spi_gphy_ctrl_mlane_if bus ();
  wire miso_w;
  pullup (miso_w);

  logic                   reset_PHY;
  logic                   pll_locked;
  logic [LANES-1:0]       tx_ready, rx_ready;
  logic [2*LANES-1:0]     rx_runningdisp, rx_disperr, rx_errdetect, rx_datak;
  logic [16*LANES-1:0]    rx_parallel_data;
  logic [16*LANES-1:0]    tx_parallel_data;
  logic [2*LANES-1:0]     tx_datak;

  spi_gphy_ctrl_mlane #(.LANES(LANES), .param_adr(ADR), .ID_VER(16'h0002)) dut (
    .clk(clk), .rst(rst), .spi(bus), .miso(miso_w), .reset_PHY(reset_PHY),
    .pll_locked(pll_locked), .tx_ready(tx_ready), .rx_ready(rx_ready),
    .rx_runningdisp(rx_runningdisp), .rx_disperr(rx_disperr),
    .rx_errdetect(rx_errdetect), .rx_datak(rx_datak),
    .rx_parallel_data(rx_parallel_data), .tx_parallel_data(tx_parallel_data),
    .tx_datak(tx_datak)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: register contents as the SPI master should see them.
  logic                ctrl_m;
  logic [17:0]         tx_m   [8];
  logic [15:0]         disp_m [8];
  logic [15:0]         det_m  [8];
  logic                snap_pll;
  logic [LANES-1:0]    snap_txr, snap_rxr;
  logic [2*LANES-1:0]  snap_rd, snap_de, snap_ed, snap_dk;
  logic [16*LANES-1:0] snap_data;

  task automatic mdl_reset();
    ctrl_m = 1'b0;
    for (int n = 0; n < 8; n++) begin
      tx_m[n] = '0; disp_m[n] = '0; det_m[n] = '0;
    end
  endtask

  task automatic mdl_write(input logic [7:0] idx, input logic [31:0] d);
    int n;
    n = int'(idx[3:0]);
    if (idx == 8'h00) begin
      ctrl_m = d[0];
      if (d[1]) for (int k = 0; k < 8; k++) begin disp_m[k] = '0; det_m[k] = '0; end
    end
    if (n < int'(LANES) && idx[7:4] == 4'h1) tx_m[n] = d[17:0];
    if (n < int'(LANES) && idx[7:4] == 4'h3) begin disp_m[n] = '0; det_m[n] = '0; end
  endtask

  function automatic logic [31:0] mdl_read(input logic [7:0] idx);
    int n;
    n = int'(idx[3:0]);
    if (idx == 8'h00) return {31'b0, ctrl_m};
    if (idx == 8'h01) return {8'hA5, 8'(LANES), 16'h0002};
    if (n >= int'(LANES)) return 32'h0;
    case (idx[7:4])
      4'h1: return {14'b0, tx_m[n]};
      4'h2: return {5'b0, snap_pll, snap_txr[n], snap_rxr[n], snap_rd[2*n +: 2],
                    snap_de[2*n +: 2], snap_ed[2*n +: 2], snap_dk[2*n +: 2],
                    snap_data[16*n +: 16]};
      4'h3: return {disp_m[n], det_m[n]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic scramble_status();
    pll_locked       = 1'($urandom);
    tx_ready         = LANES'($urandom);
    rx_ready         = LANES'($urandom);
    rx_runningdisp   = (2*LANES)'($urandom);
    rx_datak         = (2*LANES)'($urandom);
    rx_parallel_data = (16*LANES)'($urandom);
  endtask

  // One SPI mode-0 frame; sclk half period is 4 clk. rst_at>=0 pulses rst before that bit's falling edge.
  task automatic xfer(input logic [7:0] b0, input logic [7:0] b1, input logic [31:0] wd,
                      input int nbits, input int rst_at,
                      output logic [31:0] rd, output int hdr_drv, output logic rel_after);
    logic [47:0] bits;
    bits = {b0, b1, wd};
    rd = '0;
    hdr_drv = 0;
    snap_pll = pll_locked; snap_txr = tx_ready; snap_rxr = rx_ready;
    snap_rd = rx_runningdisp; snap_de = rx_disperr; snap_ed = rx_errdetect;
    snap_dk = rx_datak; snap_data = rx_parallel_data;
    @(negedge clk); bus.cs = 1'b0;
    repeat (4) @(negedge clk);
    scramble_status();
    for (int i = 0; i < 16 + nbits; i++) begin
      bus.mosi = bits[47 - i];
      repeat (4) @(negedge clk);
      if (i < 16) begin
        if (miso_w !== 1'b1) hdr_drv++;
      end else begin
        rd = {rd[30:0], miso_w};
      end
      bus.sclk = 1'b1;
      if (i == rst_at) begin
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        mdl_reset();
      end
      repeat (4) @(negedge clk);
      bus.sclk = 1'b0;
    end
    repeat (4) @(negedge clk);
    bus.cs = 1'b1;
    repeat (4) @(negedge clk);
    rel_after = (miso_w === 1'b1);
    if (rst_at < 0 && nbits == 32 && b0 == {1'b1, ADR}) mdl_write(b1, wd);
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_txdata"}, tx_parallel_data, {tx_m[1][15:0], tx_m[0][15:0]});
    chk({tag, "_ctl"}, {27'b0, reset_PHY, tx_datak}, {27'b0, ctrl_m, tx_m[1][17:16], tx_m[0][17:16]});
  endtask

  logic [31:0] rd;
  int          hdr;
  logic        rel;
  int          nerr;
  logic [7:0]  idx_tab [14];

  initial begin
    idx_tab = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h12, 8'h17, 8'h20, 8'h21,
                8'h22, 8'h30, 8'h31, 8'h32, 8'h3F, 8'h55};
    bus.cs = 1'b1; bus.sclk = 1'b0; bus.mosi = 1'b0;
    pll_locked = 1'b0; tx_ready = '0; rx_ready = '0; rx_runningdisp = '0;
    rx_disperr = '0; rx_errdetect = '0; rx_datak = '0; rx_parallel_data = '0;
    mdl_reset();
    repeat (5) @(negedge clk);
    chk("rst_reset_phy", {31'b0, reset_PHY}, 32'h0);
    chk("rst_tx", tx_parallel_data, 32'h0);
    chk("rst_txk", {28'b0, tx_datak}, 32'h0);
    chk("rst_miso_rel", {31'b0, miso_w}, 32'h1);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // TX lane 0 write
    xfer(8'h81, 8'h10, 32'h0001BC50, 32, -1, rd, hdr, rel);
    chk("wr_tx0_k", {30'b0, tx_datak[1:0]}, 32'h1);
    chk("wr_tx0_d", {16'b0, tx_parallel_data[15:0]}, 32'hBC50);
    chk("wr_miso_rel", rd, 32'hFFFF_FFFF);

    // ID read with release before data and after cs
    xfer(8'h01, 8'h01, 32'h0, 32, -1, rd, hdr, rel);
    chk("id_read", rd, 32'hA502_0002);
    chk("id_hdr_rel", 32'(hdr), 32'h0);
    chk("id_after_rel", {31'b0, rel}, 32'h1);

    // Wrong block address
    xfer(8'h85, 8'h00, 32'h1, 32, -1, rd, hdr, rel);
    chk("badadr_miso", rd, 32'hFFFF_FFFF);
    chk("badadr_hdr", 32'(hdr), 32'h0);
    chk_outputs("badadr");

    // Aborted then full CTRL write
    xfer(8'h81, 8'h00, 32'h1, 20, -1, rd, hdr, rel);
    chk("abort_rphy", {31'b0, reset_PHY}, 32'h0);
    xfer(8'h81, 8'h00, 32'h1, 32, -1, rd, hdr, rel);
    chk("full_rphy", {31'b0, reset_PHY}, 32'h1);
    xfer(8'h81, 8'h00, 32'h3, 32, -1, rd, hdr, rel);
    xfer(8'h01, 8'h00, 32'h0, 32, -1, rd, hdr, rel);
    chk("ctrl_bit1_rd0", rd, 32'h1);

    // Reset pulse during data phase of a TX write
    xfer(8'h81, 8'h11, 32'h0002ABCD, 32, 26, rd, hdr, rel);
    chk_outputs("midrst");
    chk("midrst_tx", tx_parallel_data, 32'h0);
    xfer(8'h81, 8'h11, 32'h0002ABCD, 32, -1, rd, hdr, rel);
    chk_outputs("postrst");
    xfer(8'h01, 8'h11, 32'h0, 32, -1, rd, hdr, rel);
    chk("postrst_rd", rd, 32'h0002_ABCD);

    // Error counters: saturation, exact count, clear against an active increment
    xfer(8'h81, 8'h00, 32'h2, 32, -1, rd, hdr, rel);
    nerr = int'($urandom_range(100, 400));
    @(negedge clk);
    rx_errdetect = 4'b0010;
    rx_disperr   = 4'b0100;
    repeat (nerr) @(negedge clk);
    rx_errdetect = '0;
    repeat (66000 - nerr) @(negedge clk);
    xfer(8'h01, 8'h31, 32'h0, 32, -1, rd, hdr, rel);
    chk("errcnt1_sat", rd, 32'hFFFF_0000);
    xfer(8'h01, 8'h30, 32'h0, 32, -1, rd, hdr, rel);
    chk("errcnt0_exact", rd, {16'h0, 16'(nerr)});
    xfer(8'h81, 8'h31, 32'h1234_5678, 32, -1, rd, hdr, rel);
    rx_disperr = '0;
    xfer(8'h01, 8'h31, 32'h0, 32, -1, rd, hdr, rel);
    chk("errcnt_clr_wins", {31'b0, (rd[31:16] < 16'd40) && (rd[15:0] == 16'h0)}, 32'h1);
    xfer(8'h81, 8'h31, 32'h0, 32, -1, rd, hdr, rel);
    xfer(8'h01, 8'h31, 32'h0, 32, -1, rd, hdr, rel);
    chk("errcnt1_zero", rd, 32'h0);
    xfer(8'h01, 8'h30, 32'h0, 32, -1, rd, hdr, rel);
    chk("errcnt0_kept", rd, {16'h0, 16'(nerr)});
    xfer(8'h81, 8'h00, 32'h2, 32, -1, rd, hdr, rel);
    xfer(8'h01, 8'h30, 32'h0, 32, -1, rd, hdr, rel);
    chk("errcnt0_clrall", rd, 32'h0);

    // Randomised frames against the model
    for (int t = 0; t < 16; t++) begin
      logic [7:0]  idx;
      logic        rw;
      logic [6:0]  adr;
      logic [31:0] wd, exp;
      int          nb;
      idx = idx_tab[$urandom_range(0, 13)];
      rw  = 1'($urandom);
      adr = ($urandom_range(0, 5) == 0) ? 7'($urandom_range(2, 127)) : ADR;
      wd  = $urandom;
      nb  = (rw && $urandom_range(0, 5) == 0) ? int'($urandom_range(1, 31)) : 32;
      scramble_status();
      xfer({rw, adr}, idx, wd, nb, -1, rd, hdr, rel);
      chk("rnd_hdr_rel", 32'(hdr), 32'h0);
      if (!rw && adr == ADR) begin
        exp = mdl_read(idx);
        chk($sformatf("rnd_rd_%02h", idx), rd, exp);
      end else if (nb == 32) begin
        chk("rnd_miso_rel", rd, 32'hFFFF_FFFF);
      end
      chk_outputs("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
